door_arbiter: RTL and testbench
===============================

# door_arbiter

Sequencing controller for the shared door. It arbitrates between entrance and exit requesters and gates each passage on a valid card within a timeout window. It holds the door open for a fixed time and tracks room occupancy against a capacity limit. It sits between the sensors/card reader and the door actuator and indicator LEDs, and replaces ad-hoc combinational door control.

## Interface
- OPEN_CYCLES, 16: cycles the door stays open per granted passage (≥1)
- DENY_CYCLES, 8: cycles RED_LED is held after a card timeout (≥1)
- CARD_TIMEOUT, 32: cycles a granted requester has to present a card (≥1)
- CAPACITY, 8: maximum occupancy; must satisfy CAPACITY < 2^CNT_W
- CNT_W, 4: occupancy counter width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- sensor_entrance  in  1  level: person waiting at entrance
- sensor_exit  in  1  level: person waiting at exit
- card_valid  in  1  card reader reports valid card (sampled only in WAIT_CARD)
- grant_entrance  out  1  entrance side owns the door (WAIT_CARD/OPEN/DENY)
- grant_exit  out  1  exit side owns the door
- door_status  out  1  door open command
- GREEN_LED  out  1  high while door open
- RED_LED  out  1  high during DENY
- occupancy  out  CNT_W  current head count
- full  out  1  occupancy == CAPACITY

## Operation
- States: IDLE, WAIT_CARD, OPEN, DENY. Registers: state, owner (ENT/EXT), last_owner, timer, occupancy.
- Eligibility in IDLE: entrance requires sensor_entrance && !full. Exit requires sensor_exit && occupancy != 0.
- IDLE: one eligible side → grant it. Both eligible → grant the side opposite last_owner (round-robin). None eligible → stay. On grant: owner := side, timer := 0, go WAIT_CARD.
- WAIT_CARD:
  - card_valid → OPEN, timer := 0.
  - Otherwise, owner's sensor low → IDLE (abandon; last_owner := owner; no count change).
  - Otherwise, timer == CARD_TIMEOUT-1 → DENY, timer := 0.
  - Otherwise timer++.
  - card_valid wins over both abandon and timeout in the same cycle.
- OPEN: card_valid and sensors ignored. timer++. When timer == OPEN_CYCLES-1 → IDLE, last_owner := owner, occupancy +1 (ENT) or −1 (EXT).
- DENY: timer++. When timer == DENY_CYCLES-1 → IDLE, last_owner := owner. Occupancy unchanged.
- Occupancy never wraps: eligibility rules guarantee 0 ≤ occupancy ≤ CAPACITY.
- Outputs are Moore-decoded from registered state/owner:
  - grant_entrance = (state != IDLE) && owner == ENT; grant_exit likewise for EXT.
  - door_status = GREEN_LED = (state == OPEN).
  - RED_LED = (state == DENY).
  - full = (occupancy == CAPACITY).
- Reset (reset low at a clock edge, in any state including mid-OPEN):
  - state IDLE, owner ENT, last_owner EXT (entrance wins the first tie), timer 0, occupancy 0.
  - All outputs 0. A passage in progress is dropped without a count update.

## Timing
- Request sampled high in IDLE at edge N → grant visible after edge N (cycle N+1). WAIT_CARD entered.
- card_valid sampled at edge M → door_status high from edge M for exactly OPEN_CYCLES cycles.
- No card: WAIT_CARD lasts exactly CARD_TIMEOUT cycles, then RED_LED high for exactly DENY_CYCLES cycles.
- Occupancy and full update at the same edge that returns state to IDLE.
- IDLE lasts ≥1 cycle between consecutive grants. Minimum per-passage period is 1 + 1 + OPEN_CYCLES cycles.
- Grant, door and LED outputs are mutually consistent each cycle. grant_entrance and grant_exit are never both high.

## Test plan
- Reset, then sensor_entrance=1, card_valid pulse 3 cycles after grant → grant_entrance at cycle 1, door_status/GREEN_LED high exactly 16 cycles, occupancy 0→1, RED_LED never high.
- Both sensors high after reset with occupancy=2, cards given promptly → order ENT, EXT, ENT, EXT; occupancy sequence 3,2,3,2; no two grants overlap.
- sensor_entrance=1, no card → grant held 32 cycles, then RED_LED high 8 cycles, door_status stays 0, occupancy unchanged, then re-grant.
- Fill to CAPACITY=8 then sensor_entrance=1 only → full=1, no grant. Raise sensor_exit with card → exit granted, occupancy 7, full=0, entrance granted next.
- card_valid and sensor drop on the same cycle as timer == 31 → OPEN entered (card wins).
- Assert reset low mid-OPEN (cycle 5 of 16) → next cycle door_status=0, all grants 0, occupancy=0, state IDLE.

Source files
------------

// File: rtl/door_arbiter.sv
// Shared-door sequencer: round-robin arbitration between entrance and exit,
// card-gated passage with timeout, fixed open time and occupancy tracking.
module door_arbiter #(
  parameter int OPEN_CYCLES  = 16,
  parameter int DENY_CYCLES  = 8,
  parameter int CARD_TIMEOUT = 32,
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_entrance,
  input  logic             sensor_exit,
  input  logic             card_valid,
  output logic             grant_entrance,
  output logic             grant_exit,
  output logic             door_status,
  output logic             GREEN_LED,
  output logic             RED_LED,
  output logic [CNT_W-1:0] occupancy,
  output logic             full
);

  localparam int TMAX0 = (OPEN_CYCLES > DENY_CYCLES) ? OPEN_CYCLES : DENY_CYCLES;
  localparam int TMAX  = (TMAX0 > CARD_TIMEOUT) ? TMAX0 : CARD_TIMEOUT;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] DENY_LAST = TW'(DENY_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(CARD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_CARD, OPEN, DENY} state_e;
  typedef enum logic {ENT, EXT} side_e;

  state_e           state_q;
  side_e            owner_q;
  side_e            last_q;
  logic [TW-1:0]    timer_q;
  logic [CNT_W-1:0] occ_q;

  logic full_w;
  logic ent_ok;
  logic ext_ok;
  logic owner_sensor;

  assign full_w       = (occ_q == CNT_W'(CAPACITY));
  assign ent_ok       = sensor_entrance && !full_w;
  assign ext_ok       = sensor_exit && (occ_q != '0);
  assign owner_sensor = (owner_q == ENT) ? sensor_entrance : sensor_exit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= ENT;
      last_q  <= EXT;
      timer_q <= '0;
      occ_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ent_ok || ext_ok) begin
            state_q <= WAIT_CARD;
            timer_q <= '0;
            // On a tie the side that did not go last wins.
            if (ent_ok && ext_ok) owner_q <= (last_q == ENT) ? EXT : ENT;
            else                  owner_q <= ent_ok ? ENT : EXT;
          end
        end
        WAIT_CARD: begin
          if (card_valid) begin
            state_q <= OPEN;
            timer_q <= '0;
          end else if (!owner_sensor) begin
            state_q <= IDLE;
            last_q  <= owner_q;
          end else if (timer_q == WAIT_LAST) begin
            state_q <= DENY;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        OPEN: begin
          if (timer_q == OPEN_LAST) begin
            state_q <= IDLE;
            last_q  <= owner_q;
            occ_q   <= (owner_q == ENT) ? occ_q + CNT_W'(1) : occ_q - CNT_W'(1);
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DENY: begin
          if (timer_q == DENY_LAST) begin
            state_q <= IDLE;
            last_q  <= owner_q;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_entrance = (state_q != IDLE) && (owner_q == ENT);
  assign grant_exit     = (state_q != IDLE) && (owner_q == EXT);
  assign door_status    = (state_q == OPEN);
  assign GREEN_LED      = (state_q == OPEN);
  assign RED_LED        = (state_q == DENY);
  assign occupancy      = occ_q;
  assign full           = full_w;

endmodule

// File: tb/tb_door_arbiter.sv
// Bench for door_arbiter: directed scenarios plus random traffic, all checked
// against a countdown-based passage model.
module tb_door_arbiter;
  localparam int OPEN_C = 16;
  localparam int DENY_C = 8;
  localparam int TMO    = 32;
  localparam int CAP    = 8;
  localparam int CW     = 4;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_OPEN = 2;
  localparam int P_DENY = 3;

  logic clk = 1'b0;
  logic reset, se, sx, cv;
  logic grant_entrance, grant_exit, door_status, GREEN_LED, RED_LED, full;
  logic [CW-1:0] occupancy;

  int total = 0;
  int bad   = 0;

  int m_phase, m_left, m_occ;
  bit m_ent, m_last_ent;

  always #5 clk = ~clk;

  door_arbiter #(
    .OPEN_CYCLES(OPEN_C), .DENY_CYCLES(DENY_C), .CARD_TIMEOUT(TMO),
    .CAPACITY(CAP), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .sensor_entrance(se), .sensor_exit(sx),
    .card_valid(cv), .grant_entrance(grant_entrance), .grant_exit(grant_exit),
    .door_status(door_status), .GREEN_LED(GREEN_LED), .RED_LED(RED_LED),
    .occupancy(occupancy), .full(full)
  );

  wire [9:0] dut_vec = {grant_entrance, grant_exit, door_status, GREEN_LED,
                        RED_LED, full, occupancy};

  // Passage model: each phase is a countdown of remaining cycles.
  task automatic model_step();
    bit e, x;
    e = se && (m_occ < CAP);
    x = sx && (m_occ > 0);
    if (!reset) begin
      m_phase = P_IDLE; m_ent = 1'b1; m_last_ent = 1'b0; m_left = 0; m_occ = 0;
      return;
    end
    case (m_phase)
      P_IDLE: if (e || x) begin
        m_ent   = (e && x) ? !m_last_ent : e;
        m_phase = P_WAIT;
        m_left  = TMO;
      end
      P_WAIT: begin
        if (cv) begin m_phase = P_OPEN; m_left = OPEN_C; end
        else if (!(m_ent ? se : sx)) begin m_phase = P_IDLE; m_last_ent = m_ent; end
        else if (m_left == 1) begin m_phase = P_DENY; m_left = DENY_C; end
        else m_left--;
      end
      P_OPEN: begin
        if (m_left == 1) begin
          m_phase = P_IDLE; m_last_ent = m_ent;
          m_occ = m_ent ? m_occ + 1 : m_occ - 1;
        end else m_left--;
      end
      P_DENY: begin
        if (m_left == 1) begin m_phase = P_IDLE; m_last_ent = m_ent; end
        else m_left--;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  function automatic logic [9:0] exp_vec();
    logic ge, gx, dr, rd, fl;
    ge = (m_phase != P_IDLE) && m_ent;
    gx = (m_phase != P_IDLE) && !m_ent;
    dr = (m_phase == P_OPEN);
    rd = (m_phase == P_DENY);
    fl = (m_occ == CAP);
    return {ge, gx, dr, dr, rd, fl, CW'(m_occ)};
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; se = 1'b0; sx = 1'b0; cv = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; se = 1'b1; sx = 1'b1; cv = 1'b1;
    cyc(); cyc();
    total++;
    if (dut_vec !== 10'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec, 10'b0);
    end
    total++;
    if (dut_vec !== exp_vec()) begin
      bad++; $display("FAIL reset_model got=%b exp=%b", dut_vec, exp_vec());
    end
    reset = 1'b1; se = 1'b0; sx = 1'b0; cv = 1'b0;
  endtask

  task automatic test_entry_pass();
    int door_cnt;
    bit red_seen;
    do_reset();
    se = 1'b1;
    cyc();
    total++;
    if (grant_entrance !== 1'b1 || grant_exit !== 1'b0) begin
      bad++; $display("FAIL entry_grant got=%b%b exp=10", grant_entrance, grant_exit);
    end
    cyc(); cyc();
    cv = 1'b1; se = 1'b0;
    cyc();
    cv = 1'b0;
    door_cnt = door_status ? 1 : 0;
    red_seen = RED_LED;
    for (int i = 0; i < 19; i++) begin
      cyc();
      if (door_status) door_cnt++;
      if (RED_LED) red_seen = 1'b1;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL entry_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
    total++;
    if (door_cnt !== OPEN_C) begin
      bad++; $display("FAIL entry_open_len got=%0d exp=%0d", door_cnt, OPEN_C);
    end
    total++;
    if (occupancy !== CW'(1) || red_seen) begin
      bad++; $display("FAIL entry_occ got=%0d red=%0d exp=1 red=0", occupancy, red_seen);
    end
  endtask

  task automatic test_round_robin();
    int ord[$];
    int occs[$];
    bit pge, pgx, pdr;
    int exp_ord[4] = '{0, 1, 0, 1};
    int exp_occ[4] = '{3, 2, 3, 2};
    do_reset();
    se = 1'b1; cv = 1'b1;
    for (int i = 0; i < 54; i++) begin
      cyc();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL rr_fill cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
    se = 1'b0; sx = 1'b1;
    repeat (18) cyc();
    sx = 1'b0;
    total++;
    if (occupancy !== CW'(2)) begin
      bad++; $display("FAIL rr_setup_occ got=%0d exp=2", occupancy);
    end
    se = 1'b1; sx = 1'b1; cv = 1'b1;
    pge = grant_entrance; pgx = grant_exit; pdr = door_status;
    for (int i = 0; i < 72; i++) begin
      cyc();
      if (grant_entrance && !pge) ord.push_back(0);
      if (grant_exit && !pgx) ord.push_back(1);
      if (pdr && !door_status) occs.push_back(int'(occupancy));
      total++;
      if (grant_entrance && grant_exit) begin
        bad++; $display("FAIL rr_both_grants cyc=%0d got=11 exp=not both", i);
      end
      pge = grant_entrance; pgx = grant_exit; pdr = door_status;
    end
    se = 1'b0; sx = 1'b0; cv = 1'b0;
    total++;
    if (ord.size() != 4 || occs.size() != 4) begin
      bad++; $display("FAIL rr_counts got=%0d/%0d exp=4/4", ord.size(), occs.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (ord[k] != exp_ord[k] || occs[k] != exp_occ[k]) begin
          bad++; $display("FAIL rr_seq k=%0d got=%0d/%0d exp=%0d/%0d",
                          k, ord[k], occs[k], exp_ord[k], exp_occ[k]);
        end
      end
    end
  endtask

  task automatic test_timeout_deny();
    int waitcnt, redcnt, doorcnt;
    bit red_seen;
    do_reset();
    se = 1'b1; cv = 1'b0;
    waitcnt = 0; redcnt = 0; doorcnt = 0; red_seen = 1'b0;
    for (int i = 0; i < 42; i++) begin
      cyc();
      if (RED_LED) begin red_seen = 1'b1; redcnt++; end
      else if (!red_seen && grant_entrance) waitcnt++;
      if (door_status) doorcnt++;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL tmo_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
    total++;
    if (waitcnt != TMO || redcnt != DENY_C) begin
      bad++; $display("FAIL tmo_lengths got=%0d/%0d exp=%0d/%0d", waitcnt, redcnt, TMO, DENY_C);
    end
    total++;
    if (doorcnt != 0 || occupancy !== CW'(0) || grant_entrance !== 1'b1) begin
      bad++; $display("FAIL tmo_after got door=%0d occ=%0d regrant=%b exp 0/0/1",
                      doorcnt, occupancy, grant_entrance);
    end
    se = 1'b0;
  endtask

  task automatic test_full();
    int ord[$];
    int occs[$];
    bit fulls[$];
    bit pge, pgx, pdr;
    do_reset();
    se = 1'b1; cv = 1'b1;
    for (int i = 0; i < 144; i++) begin
      cyc();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL full_fill cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
    cv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if (grant_entrance !== 1'b0 || full !== 1'b1 || occupancy !== CW'(CAP)) begin
        bad++; $display("FAIL full_block got g=%b full=%b occ=%0d exp 0/1/%0d",
                        grant_entrance, full, occupancy, CAP);
      end
    end
    sx = 1'b1; cv = 1'b1;
    pge = grant_entrance; pgx = grant_exit; pdr = door_status;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (grant_entrance && !pge) ord.push_back(0);
      if (grant_exit && !pgx) ord.push_back(1);
      if (pdr && !door_status) begin occs.push_back(int'(occupancy)); fulls.push_back(full); end
      pge = grant_entrance; pgx = grant_exit; pdr = door_status;
    end
    se = 1'b0; sx = 1'b0; cv = 1'b0;
    total++;
    if (ord.size() < 2 || ord[0] != 1 || ord[1] != 0) begin
      bad++; $display("FAIL full_order got n=%0d exp EXT then ENT", ord.size());
    end
    total++;
    if (occs.size() < 1 || occs[0] != CAP - 1 || fulls[0] != 1'b0) begin
      bad++; $display("FAIL full_exit_occ got n=%0d exp occ=%0d full=0", occs.size(), CAP - 1);
    end
  endtask

  task automatic test_card_wins();
    do_reset();
    se = 1'b1; cv = 1'b0;
    repeat (TMO) cyc();
    cv = 1'b1; se = 1'b0;
    cyc();
    cv = 1'b0;
    total++;
    if (door_status !== 1'b1 || RED_LED !== 1'b0) begin
      bad++; $display("FAIL card_wins got door=%b red=%b exp 1/0", door_status, RED_LED);
    end
    for (int i = 0; i < OPEN_C; i++) begin
      cyc();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL card_wins_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
    total++;
    if (occupancy !== CW'(1)) begin
      bad++; $display("FAIL card_wins_occ got=%0d exp=1", occupancy);
    end
  endtask

  task automatic test_reset_mid_open();
    do_reset();
    se = 1'b1; cv = 1'b1;
    cyc(); cyc();
    se = 1'b0; cv = 1'b0;
    repeat (4) cyc();
    total++;
    if (door_status !== 1'b1) begin
      bad++; $display("FAIL midopen_pre got door=%b exp=1", door_status);
    end
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    total++;
    if (dut_vec !== 10'b0) begin
      bad++; $display("FAIL midopen_reset got=%b exp=%b", dut_vec, 10'b0);
    end
    repeat (3) cyc();
    total++;
    if (dut_vec !== exp_vec() || occupancy !== CW'(0)) begin
      bad++; $display("FAIL midopen_after got=%b exp=%b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      se    = ($urandom_range(0, 1) == 1);
      sx    = ($urandom_range(0, 1) == 1);
      cv    = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 499) != 0);
      cyc();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL random_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      total++;
      if (grant_entrance && grant_exit) begin
        bad++; $display("FAIL random_both_grants cyc=%0d got=11 exp=not both", i);
      end
    end
    reset = 1'b1; se = 1'b0; sx = 1'b0; cv = 1'b0;
  endtask

  initial begin
    reset = 1'b0; se = 1'b0; sx = 1'b0; cv = 1'b0;
    m_phase = P_IDLE; m_ent = 1'b1; m_last_ent = 1'b0; m_left = 0; m_occ = 0;
    test_reset();
    test_entry_pass();
    test_round_robin();
    test_timeout_deny();
    test_full();
    test_card_wins();
    test_reset_mid_open();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
